tl_ul_arb2: RTL and testbench
=============================

Name: tl_ul_arb2

Overview:
- Two-master TileLink-UL (single-beat) arbiter that shares one downstream A/D channel pair between two upstream requesters.
- Sits between the core-side TL-UL master ports and the channel pass-through bundle feeding the slave fabric.
- Round-robin A-channel arbitration with grant lock, source-ID tagging, D-channel response routing and per-master outstanding-request throttling.

Parameters:
- SRC_W, 2, upstream source ID width; the downstream source ID is SRC_W+1 bits.
- MAX_OUT, 4, maximum outstanding A requests per master (1..15).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mN_a_valid  in  1  master N (N=0,1) A-channel valid.
- mN_a_ready  out  1  master N A-channel ready.
- mN_a_opcode  in  3  A opcode.
- mN_a_param  in  3  A param.
- mN_a_size  in  2  log2 of the byte count.
- mN_a_source  in  SRC_W  source ID.
- mN_a_address  in  32  byte address.
- mN_a_mask  in  4  byte lanes.
- mN_a_data  in  32  write data.
- mN_d_valid  out  1  D-channel valid.
- mN_d_ready  in  1  D-channel ready.
- mN_d_opcode  out  3  D opcode.
- mN_d_size  out  2  D size.
- mN_d_source  out  SRC_W  D source with the tag bit stripped.
- mN_d_data  out  32  read data.
- mN_d_error  out  1  D denied/corrupt.
- s_a_valid, s_a_opcode[3], s_a_param[3], s_a_size[2], s_a_source[SRC_W+1], s_a_address[32], s_a_mask[4], s_a_data[32]  out  downstream A channel.
- s_a_ready  in  1  downstream A ready.
- s_d_valid, s_d_opcode[3], s_d_size[2], s_d_source[SRC_W+1], s_d_data[32], s_d_error  in  downstream D channel.
- s_d_ready  out  1  downstream D ready.
- err_unexp_d  out  1  sticky flag: a D beat arrived for a master with zero outstanding requests.

Behaviour:
- State registers: prio (0 = m0 preferred), lock, lock_sel, cnt0, cnt1 (each clog2(MAX_OUT+1) bits), err_unexp_d.
- Reset values (async, immediate): prio=0, lock=0, lock_sel=0, cnt0=cnt1=0, err_unexp_d=0.
- Master N is eligible when mN_a_valid=1 and cntN<MAX_OUT.

A-channel selection:
- If lock=1: sel=lock_sel.
- Otherwise, if both masters are eligible: sel=prio.
- Otherwise: sel = whichever master is eligible.
- If no master is eligible: s_a_valid=0 and both mN_a_ready=0.
- s_a_valid = eligible(sel).
- s_a_* fields come from master sel; s_a_source = {sel, mSEL_a_source}.
- mSEL_a_ready = s_a_ready & eligible(sel). The other master's a_ready=0.
- A fire = s_a_valid & s_a_ready. Grant is combinational, so latency is zero cycles from master to downstream.

Lock (TL valid/payload stability):
- If s_a_valid=1 and s_a_ready=0: next lock=1 and lock_sel=sel.
- On A fire: lock=0.
- While locked, the other master cannot steal the grant even if it has higher priority.
- The throttle cannot drop a locked master's eligibility, because cnt only increments on fire.

Priority:
- On A fire: prio = ~sel.
- With no fire, prio is unchanged.

D-channel routing:
- r = s_d_source[SRC_W].
- mR_d_valid = s_d_valid. The other master's d_valid=0.
- s_d_ready = mR_d_ready.
- D payload goes to both masters. mN_d_source = s_d_source[SRC_W-1:0].
- Pass-through is combinational; there is no D-side buffering.

Counters:
- cntN += 1 on an A fire with sel=N.
- cntN -= 1 on a D fire (s_d_valid & s_d_ready) with r=N.
- A simultaneous increment and decrement on the same counter leaves it unchanged.
- Decrement when cntN=0: the counter saturates at 0 and err_unexp_d is set. It stays set until reset.
- Increment never exceeds MAX_OUT, because eligibility blocks it.

Reset mid-transaction:
- Lock and counters clear immediately.
- Downstream responses to pre-reset requests are treated as unexpected. They set err_unexp_d and are still routed by the tag bit.

Test Plan:
- Both masters valid continuously, s_a_ready=1 → fires alternate m0,m1,m0,m1. s_a_source MSB follows 0,1,0,1.
- m1 granted with s_a_ready=0 for 3 cycles while m0 is also valid and prio=1 → s_a_address stays at m1's value for all 3 cycles. m1 fires in cycle 4. m0 fires in the next cycle.
- MAX_OUT=4, m0 issues 4 requests with no D beats → cnt0=4 and m0_a_ready=0. m1 is still granted. One D beat with source MSB=0 → cnt0=3 and m0 is accepted again.
- D beat with s_d_source=3'b110 while m1_d_ready=0 → m1_d_valid=1, s_d_ready=0, m1_d_source=2'b10, m0_d_valid=0. When m1_d_ready=1, cnt1 decrements.
- Same-cycle A fire and D fire for m0 with cnt0=2 → cnt0 stays 2.
- D beat for m1 with cnt1=0 → err_unexp_d=1 and cnt1 stays 0. Assert reset mid-lock → lock=0, prio=0, err_unexp_d=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/tl_ul_arb2_if.sv
// Single-beat TL-UL A/D channel bundle. SW sets the source ID width, so the
// tagged downstream side can be one bit wider than the upstream ports.
interface tl_ul_arb2_if #(parameter int SW = 2);
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [2:0]    a_param;
  logic [1:0]    a_size;
  logic [SW-1:0] a_source;
  logic [31:0]   a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_size;
  logic [SW-1:0] d_source;
  logic [31:0]   d_data;
  logic          d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data, d_error,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data, d_error,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_arb2.sv
// Two-master TL-UL arbiter: round-robin A grant with stall lock, source tagging,
// D routing by tag bit and a per-master outstanding-request throttle.
module tl_ul_arb2_thr #(
  parameter int MAX_OUT = 4,
  parameter int CW      = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic a_valid,
  input  logic inc,
  input  logic dec,
  output logic elig,
  output logic unexp
);
  logic [CW-1:0] cnt;

  assign elig  = a_valid && (cnt < CW'(MAX_OUT));
  assign unexp = dec && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (inc && !dec)               cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)  cnt <= cnt - 1'b1;
  end
endmodule

module tl_ul_arb2 #(
  parameter int SRC_W   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic          clock,
  input  logic          reset,
  tl_ul_arb2_if.slave   m0,
  tl_ul_arb2_if.slave   m1,
  tl_ul_arb2_if.master  s,
  output logic          err_unexp_d
);
  localparam int NUM_M = 2;
  localparam int CW    = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       param;
    logic [1:0]       size;
    logic [SRC_W-1:0] source;
    logic [31:0]      address;
    logic [3:0]       mask;
    logic [31:0]      data;
  } a_req_t;

  a_req_t [NUM_M-1:0] req;
  logic   [NUM_M-1:0] a_valid, elig, inc, dec, unexp;
  logic               prio, lock, lock_sel, sel, a_fire, d_fire, r;

  assign req[0]  = {m0.a_opcode, m0.a_param, m0.a_size, m0.a_source,
                    m0.a_address, m0.a_mask, m0.a_data};
  assign req[1]  = {m1.a_opcode, m1.a_param, m1.a_size, m1.a_source,
                    m1.a_address, m1.a_mask, m1.a_data};
  assign a_valid = {m1.a_valid, m0.a_valid};

  // A stalled grant stays with its master until it fires, regardless of prio.
  always_comb begin
    sel = prio;
    if (lock)              sel = lock_sel;
    else if (&elig)        sel = prio;
    else                   sel = elig[1];
  end

  assign s.a_valid   = elig[sel];
  assign a_fire      = s.a_valid & s.a_ready;
  assign s.a_opcode  = req[sel].opcode;
  assign s.a_param   = req[sel].param;
  assign s.a_size    = req[sel].size;
  assign s.a_source  = {sel, req[sel].source};
  assign s.a_address = req[sel].address;
  assign s.a_mask    = req[sel].mask;
  assign s.a_data    = req[sel].data;
  assign m0.a_ready  = s.a_ready & elig[0] & ~sel;
  assign m1.a_ready  = s.a_ready & elig[1] &  sel;

  // D side: the tag bit picks the master, payload is broadcast.
  assign r          = s.d_source[SRC_W];
  assign m0.d_valid = s.d_valid & ~r;
  assign m1.d_valid = s.d_valid &  r;
  assign s.d_ready  = r ? m1.d_ready : m0.d_ready;
  assign d_fire     = s.d_valid & s.d_ready;

  assign m0.d_opcode = s.d_opcode;
  assign m0.d_size   = s.d_size;
  assign m0.d_source = s.d_source[SRC_W-1:0];
  assign m0.d_data   = s.d_data;
  assign m0.d_error  = s.d_error;
  assign m1.d_opcode = s.d_opcode;
  assign m1.d_size   = s.d_size;
  assign m1.d_source = s.d_source[SRC_W-1:0];
  assign m1.d_data   = s.d_data;
  assign m1.d_error  = s.d_error;

  for (genvar g = 0; g < NUM_M; g++) begin : g_thr
    assign inc[g] = a_fire & (sel == 1'(g));
    assign dec[g] = d_fire & (r == 1'(g));
    tl_ul_arb2_thr #(.MAX_OUT(MAX_OUT), .CW(CW)) u_thr (
      .clock   (clock),
      .reset   (reset),
      .a_valid (a_valid[g]),
      .inc     (inc[g]),
      .dec     (dec[g]),
      .elig    (elig[g]),
      .unexp   (unexp[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio        <= 1'b0;
      lock        <= 1'b0;
      lock_sel    <= 1'b0;
      err_unexp_d <= 1'b0;
    end else begin
      if (a_fire) prio <= ~sel;
      if (s.a_valid && !s.a_ready) begin
        lock     <= 1'b1;
        lock_sel <= sel;
      end else if (a_fire) begin
        lock     <= 1'b0;
      end
      if (|unexp) err_unexp_d <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: directed scenarios plus a random run, every cycle
// compared against a per-cycle reference model of the arbitration rules.
module tb_tl_ul_arb2;
  localparam int SRC_W   = 2;
  localparam int MAX_OUT = 4;

  logic clock = 1'b0;
  logic reset;
  logic err;
  always #5 clock = ~clock;

  tl_ul_arb2_if #(.SW(SRC_W))     m0_if();
  tl_ul_arb2_if #(.SW(SRC_W))     m1_if();
  tl_ul_arb2_if #(.SW(SRC_W + 1)) s_if();

  tl_ul_arb2 #(.SRC_W(SRC_W), .MAX_OUT(MAX_OUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .err_unexp_d (err)
  );

  int total = 0;
  int bad   = 0;

  // stimulus
  bit               av[2];
  logic [2:0]       op[2], pa[2];
  logic [1:0]       sz[2];
  logic [SRC_W-1:0] src[2];
  logic [31:0]      adr[2], dat[2];
  logic [3:0]       msk[2];
  bit               dr[2];
  bit               sar, dv, derr;
  logic [2:0]       dop, dsrc;
  logic [1:0]       dsz;
  logic [31:0]      ddat;

  // reference model state
  bit m_prio = 0, m_lock = 0, m_lsel = 0, m_err = 0;
  int m_cnt[2] = '{0, 0};
  bit esel, eav, eafire, er, edfire;

  logic [SRC_W:0] q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    m0_if.a_valid = av[0]; m0_if.a_opcode = op[0]; m0_if.a_param = pa[0];
    m0_if.a_size = sz[0]; m0_if.a_source = src[0]; m0_if.a_address = adr[0];
    m0_if.a_mask = msk[0]; m0_if.a_data = dat[0]; m0_if.d_ready = dr[0];
    m1_if.a_valid = av[1]; m1_if.a_opcode = op[1]; m1_if.a_param = pa[1];
    m1_if.a_size = sz[1]; m1_if.a_source = src[1]; m1_if.a_address = adr[1];
    m1_if.a_mask = msk[1]; m1_if.a_data = dat[1]; m1_if.d_ready = dr[1];
    s_if.a_ready = sar; s_if.d_valid = dv; s_if.d_opcode = dop; s_if.d_size = dsz;
    s_if.d_source = dsrc; s_if.d_data = ddat; s_if.d_error = derr;
  endtask

  task automatic idle();
    for (int n = 0; n < 2; n++) begin
      av[n] = 0; dr[n] = 0; op[n] = 3'(n); pa[n] = 0; sz[n] = 2;
      src[n] = SRC_W'(n + 1); adr[n] = 32'h1000 * (n + 1); msk[n] = 4'hf; dat[n] = 32'(n);
    end
    sar = 0; dv = 0; derr = 0; dop = 3'd1; dsrc = 0; dsz = 2; ddat = 32'hd0d0;
  endtask

  task automatic model_reset();
    m_prio = 0; m_lock = 0; m_lsel = 0; m_err = 0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic rst_now();
    apply();
    reset = 1;
    #1;
    model_reset();
    chk("rst_err", err, 0);
    #1 reset = 0;
  endtask

  // Compute what the rules require this cycle and compare with the DUT outputs.
  task automatic settle();
    bit el[2];
    apply();
    #3;
    for (int n = 0; n < 2; n++) el[n] = av[n] && (m_cnt[n] < MAX_OUT);
    if (m_lock)             esel = m_lsel;
    else if (el[0] && el[1]) esel = m_prio;
    else                    esel = el[1];
    eav    = el[esel];
    eafire = eav && sar;
    er     = dsrc[SRC_W];
    edfire = dv && (er ? dr[1] : dr[0]);
    chk("a_valid", s_if.a_valid, eav);
    if (eav)
      chk("a_payload",
          {s_if.a_source, s_if.a_opcode, s_if.a_param, s_if.a_size,
           s_if.a_address, s_if.a_mask, s_if.a_data},
          {esel, src[esel], op[esel], pa[esel], sz[esel], adr[esel], msk[esel], dat[esel]});
    chk("a_ready", {m1_if.a_ready, m0_if.a_ready},
        {esel && el[1] && sar, !esel && el[0] && sar});
    chk("d_valid", {m1_if.d_valid, m0_if.d_valid}, {dv && er, dv && !er});
    chk("d_ready", s_if.d_ready, er ? dr[1] : dr[0]);
    if (dv)
      chk("d_payload",
          {m0_if.d_source, m0_if.d_opcode, m0_if.d_size, m0_if.d_data, m0_if.d_error,
           m1_if.d_source, m1_if.d_opcode, m1_if.d_size, m1_if.d_data, m1_if.d_error},
          {dsrc[SRC_W-1:0], dop, dsz, ddat, derr, dsrc[SRC_W-1:0], dop, dsz, ddat, derr});
    chk("err_unexp_d", err, m_err);
  endtask

  task automatic tick();
    int inc, dec;
    @(posedge clock);
    if (eav && !sar) begin m_lock = 1; m_lsel = esel; end
    else if (eafire) m_lock = 0;
    if (eafire) m_prio = !esel;
    for (int n = 0; n < 2; n++) begin
      inc = (eafire && esel == n) ? 1 : 0;
      dec = (edfire && er == n) ? 1 : 0;
      if (dec == 1 && m_cnt[n] == 0) m_err = 1;
      m_cnt[n] = m_cnt[n] + inc - ((dec == 1 && (inc == 1 || m_cnt[n] > 0)) ? 1 : 0);
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    apply();
    #2;
    chk("por_a_valid", s_if.a_valid, 0);
    chk("por_err", err, 0);
    @(posedge clock);
    #1 reset = 0;

    // round robin with both masters always requesting
    idle(); rst_now();
    av[0] = 1; av[1] = 1; sar = 1;
    for (int i = 0; i < 4; i++) begin
      adr[0] = 32'h100 + i; adr[1] = 32'h200 + i;
      settle();
      chk("rr_msb", s_if.a_source[SRC_W], i % 2);
      tick();
    end

    // stall lock: m1 granted at prio=1 holds for 3 cycles
    idle(); rst_now();
    av[0] = 1; sar = 1; step();
    adr[0] = 32'hA0A0_0002; av[1] = 1; adr[1] = 32'hB0B0_0001; sar = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lock_addr", s_if.a_address, adr[1]);
      tick();
    end
    sar = 1; settle(); chk("lock_fire_m1", m1_if.a_ready, 1); tick();
    av[1] = 0; settle(); chk("m0_after", m0_if.a_ready, 1); tick();

    // lock beats priority: m1 locked at prio=0, m0 arrives later
    idle(); rst_now();
    av[1] = 1; step();
    av[0] = 1; settle(); chk("lock_hold", s_if.a_source[SRC_W], 1); tick();

    // throttle at MAX_OUT, release by a D beat, same-cycle inc/dec
    idle(); rst_now();
    av[0] = 1; sar = 1;
    for (int i = 0; i < MAX_OUT; i++) begin adr[0] = 32'h300 + i; step(); end
    av[1] = 1; settle();
    chk("thr_block", m0_if.a_ready, 0);
    chk("thr_m1_ok", m1_if.a_ready, 1);
    tick();
    av[1] = 0; dv = 1; dsrc = 3'b000; dr[0] = 1; step();
    dv = 0; settle(); chk("thr_release", m0_if.a_ready, 1); tick();
    av[0] = 0; dv = 1; step(); step();
    av[0] = 1; step();
    dv = 0; step(); step();
    settle(); chk("same_cyc", m0_if.a_ready, 0); tick();

    // D routing to m1 with backpressure, then an unexpected beat
    av[0] = 0; dv = 1; dsrc = 3'b110; dr[0] = 1; dr[1] = 0; ddat = 32'hCAFE_0001;
    settle();
    chk("d_m1_valid", m1_if.d_valid, 1);
    chk("d_s_ready", s_if.d_ready, 0);
    chk("d_m1_src", m1_if.d_source, 2'b10);
    chk("d_m0_valid", m0_if.d_valid, 0);
    tick();
    dr[1] = 1; step();
    settle(); chk("no_err_yet", err, 0); tick();
    dv = 0; settle(); chk("unexp_err", err, 1); tick();

    // asynchronous reset while m1 holds a lock
    av[1] = 1; sar = 0; step();
    av[0] = 1; apply();
    reset = 1;
    #1;
    chk("arst_err", err, 0);
    chk("arst_valid", s_if.a_valid, 1);
    chk("arst_sel", s_if.a_source[SRC_W], 0);
    model_reset();
    #1 reset = 0;
    step();

    // random traffic with a reordering downstream responder
    idle(); rst_now();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!av[n] && $urandom_range(2, 0) == 0) begin
          av[n] = 1; op[n] = 3'($urandom); pa[n] = 3'($urandom); sz[n] = 2'($urandom);
          src[n] = SRC_W'($urandom); adr[n] = $urandom; msk[n] = 4'($urandom); dat[n] = $urandom;
        end
        dr[n] = ($urandom_range(1, 0) == 1);
      end
      sar = ($urandom_range(3, 0) != 0);
      if (!dv && q.size() > 0 && $urandom_range(1, 0) == 1) begin
        int k;
        k = $urandom_range(q.size() - 1, 0);
        dsrc = q[k]; q.delete(k);
        dv = 1; dop = 3'($urandom); dsz = 2'($urandom); ddat = $urandom; derr = 1'($urandom);
      end
      step();
      if (eafire) begin
        av[esel] = 0;
        q.push_back({esel, src[esel]});
      end
      if (edfire) dv = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
